// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its write-side arbiter:
// arbiter FSM encodings and width helpers.
package sync_fifo_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Address width for a FIFO of the given depth (at least one bit).
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of a counter that must hold the value 'max_count' itself.
    function automatic int count_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set bit of req_vec, starting
// at last_idx+1 and wrapping modulo NUM_REQ.
module rr_priority_picker #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_vec,
    input  logic [$clog2(NUM_REQ)-1:0] last_idx,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] index
);

    localparam int IW = $clog2(NUM_REQ);

    // cand_idx[gi] is the requester examined at search distance gi+1.
    logic [IW-1:0]      cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_req;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand_idx[gi] = IW'((int'(last_idx) + gi + 1) % NUM_REQ);
            assign cand_req[gi] = req_vec[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest candidate inward so the nearest one wins.
    always_comb begin
        found = |cand_req;
        index = last_idx;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                index = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// MAX_BURST beats into a downstream synchronous FIFO, never writing while full.
module fifo_write_arbiter
    import sync_fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = count_width(MAX_BURST);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    arb_state_e    state_reg;
    logic [IW-1:0] grant_id_reg;
    logic [IW-1:0] last_grant_reg;
    logic [BW-1:0] beat_cnt_reg;

    logic          pick_found;
    logic [IW-1:0] pick_index;

    logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

    logic in_grant;
    logic granted_valid;
    logic beat_accept;

    assign in_grant      = (state_reg == ST_GRANT);
    assign granted_valid = req_valid[grant_id_reg];
    assign beat_accept   = in_grant & granted_valid & ~fifo_full;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign req_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = in_grant & ~fifo_full & (grant_id_reg == IW'(gi));
        end
    endgenerate

    assign fifo_w_en    = beat_accept;
    assign fifo_data_in = req_words[grant_id_reg];
    assign grant_id     = grant_id_reg;
    assign busy         = in_grant;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_vec  (req_valid),
        .last_idx (last_grant_reg),
        .found    (pick_found),
        .index    (pick_index)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            grant_id_reg   <= '0;
            beat_cnt_reg   <= '0;
            last_grant_reg <= IW'(NUM_REQ - 1);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_found && !fifo_full) begin
                        grant_id_reg <= pick_index;
                        state_reg    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // A dropped valid means no beat this edge, so it ends the burst too.
                    if ((beat_accept && beat_cnt_reg == LAST_BEAT) || !granted_valid) begin
                        state_reg      <= ST_IDLE;
                        last_grant_reg <= grant_id_reg;
                        beat_cnt_reg   <= '0;
                    end else if (beat_accept) begin
                        beat_cnt_reg <= beat_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (4 requesters, 8-bit data, bursts of 4);
// requester i sends 0xi0, 0xi1, ... and every FIFO write is logged and checked.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_w_en;
    logic [7:0]  fifo_data_in;
    logic [1:0]  grant_id;
    logic        busy;

    fifo_write_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .MAX_BURST  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_w_en    (fifo_w_en),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    int src_left [4];   // beats still to send; -1 means unlimited
    int src_cnt  [4];   // next low nibble of each requester's data

    logic [7:0] got     [$];
    int         got_gid [$];
    int         got_cyc [$];

    logic [3:0] s_ready;
    logic       s_wen;
    logic       s_busy;
    logic [1:0] s_gid;
    logic [7:0] s_data;

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (src_left[i] != 0);
            req_data[i*8 +: 8] = {4'(i), 4'(src_cnt[i])};
        end
    endtask

    task automatic reset_sources();
        for (int i = 0; i < 4; i++) begin
            src_left[i] = 0;
            src_cnt[i]  = 0;
        end
        drive();
    endtask

    task automatic clear_log();
        got.delete();
        got_gid.delete();
        got_cyc.delete();
    endtask

    // Called at a falling edge with inputs applied; samples, crosses one rising edge.
    task automatic cycle();
        #1;
        s_ready = req_ready;
        s_wen   = fifo_w_en;
        s_busy  = busy;
        s_gid   = grant_id;
        s_data  = fifo_data_in;
        if (fifo_w_en) begin
            got.push_back(fifo_data_in);
            got_gid.push_back(int'(grant_id));
            got_cyc.push_back(cyc);
            $display("[cyc %0d] write grant_id=%0d data=%02h", cyc, grant_id, fifo_data_in);
        end
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                src_cnt[i]++;
                if (src_left[i] > 0) src_left[i]--;
            end
        end
        @(negedge clk);
        cyc++;
        drive();
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (got.size() < n && k < budget) begin
            cycle();
            k++;
        end
        compared++;
        if (got.size() < n) begin
            mismatched++;
            $display("FAIL %s timeout: writes=%0d required=%0d", name, got.size(), n);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b required 0", busy); end
        compared++;
        if (fifo_w_en !== 1'b0) begin mismatched++; $display("FAIL reset_wen: got %b required 0", fifo_w_en); end
        compared++;
        if (req_ready !== 4'b0000) begin mismatched++; $display("FAIL reset_ready: got %b required 0000", req_ready); end
        compared++;
        if (grant_id !== 2'd0) begin mismatched++; $display("FAIL reset_gid: got %0d required 0", grant_id); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [7:0] exp;
        int b;
        reset_sources();
        clear_log();
        for (int i = 0; i < 4; i++) src_left[i] = -1;
        drive();
        run_until(20, 80, "rr");
        for (int i = 0; i < 4; i++) src_left[i] = 0;
        drive();
        repeat (3) cycle();
        for (int k = 0; k < 20 && k < got.size(); k++) begin
            b   = k / 4;
            exp = 8'(((b % 4) << 4) | ((b / 4) * 4 + (k % 4)));
            compared++;
            if (got[k] !== exp) begin
                mismatched++;
                $display("FAIL rr_data[%0d]: got %02h required %02h", k, got[k], exp);
            end
            compared++;
            if (got_gid[k] != b % 4) begin
                mismatched++;
                $display("FAIL rr_gid[%0d]: got %0d required %0d", k, got_gid[k], b % 4);
            end
            if (k > 0) begin
                compared++;
                if (got_cyc[k] - got_cyc[k-1] != ((k % 4 == 0) ? 2 : 1)) begin
                    mismatched++;
                    $display("FAIL rr_gap[%0d]: got %0d required %0d", k,
                             got_cyc[k] - got_cyc[k-1], (k % 4 == 0) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_single_requester();
        reset_sources();
        clear_log();
        src_left[2] = 10;
        drive();
        run_until(10, 40, "single");
        repeat (4) cycle();
        compared++;
        if (got.size() != 10) begin
            mismatched++;
            $display("FAIL single_count: got %0d required 10", got.size());
        end
        for (int k = 0; k < 10 && k < got.size(); k++) begin
            compared++;
            if (got[k] !== 8'(8'h20 + k) || got_gid[k] != 2) begin
                mismatched++;
                $display("FAIL single_beat[%0d]: got %02h gid %0d required %02h gid 2",
                         k, got[k], got_gid[k], 8'(8'h20 + k));
            end
            if (k > 0) begin
                compared++;
                if (got_cyc[k] - got_cyc[k-1] != ((k == 4 || k == 8) ? 2 : 1)) begin
                    mismatched++;
                    $display("FAIL single_gap[%0d]: got %0d required %0d", k,
                             got_cyc[k] - got_cyc[k-1], (k == 4 || k == 8) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_full_stall();
        reset_sources();
        clear_log();
        src_left[3] = 4;
        drive();
        run_until(2, 20, "stall_pre");
        fifo_full = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cycle();
            compared++;
            if (s_ready !== 4'b0000 || s_wen !== 1'b0 || s_busy !== 1'b1) begin
                mismatched++;
                $display("FAIL stall_outputs[%0d]: ready=%b wen=%b busy=%b required ready=0000 wen=0 busy=1",
                         n, s_ready, s_wen, s_busy);
            end
            compared++;
            if (dut.beat_cnt_reg !== 3'd2) begin
                mismatched++;
                $display("FAIL stall_count[%0d]: got %0d required 2", n, dut.beat_cnt_reg);
            end
        end
        fifo_full = 1'b0;
        run_until(4, 20, "stall_post");
        repeat (3) cycle();
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            compared++;
            if (got[k] !== 8'(8'h30 + k)) begin
                mismatched++;
                $display("FAIL stall_data[%0d]: got %02h required %02h", k, got[k], 8'(8'h30 + k));
            end
        end
        if (got.size() >= 3) begin
            compared++;
            if (got_cyc[2] - got_cyc[1] != 4) begin
                mismatched++;
                $display("FAIL stall_gap: got %0d required 4", got_cyc[2] - got_cyc[1]);
            end
        end
    endtask

    task automatic test_valid_drop();
        logic [7:0] exp_data [6];
        int         exp_gid  [6];
        exp_data = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h12, 8'h13};
        exp_gid  = '{0, 0, 1, 1, 1, 1};
        reset_sources();
        clear_log();
        src_left[0] = 2;
        src_left[1] = 4;
        drive();
        run_until(6, 30, "drop");
        repeat (3) cycle();
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            compared++;
            if (got[k] !== exp_data[k] || got_gid[k] != exp_gid[k]) begin
                mismatched++;
                $display("FAIL drop_beat[%0d]: got %02h gid %0d required %02h gid %0d",
                         k, got[k], got_gid[k], exp_data[k], exp_gid[k]);
            end
        end
        if (got.size() >= 3) begin
            compared++;
            if (got_cyc[2] - got_cyc[1] != 3) begin
                mismatched++;
                $display("FAIL drop_gap: got %0d required 3", got_cyc[2] - got_cyc[1]);
            end
        end
    endtask

    task automatic test_full_in_idle();
        logic [7:0] exp_data [8];
        exp_data = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h00, 8'h01, 8'h02, 8'h03};
        reset_sources();
        clear_log();
        fifo_full   = 1'b1;
        src_left[0] = 4;
        src_left[3] = 4;
        drive();
        for (int n = 0; n < 3; n++) begin
            cycle();
            compared++;
            if (s_busy !== 1'b0 || s_wen !== 1'b0 || s_ready !== 4'b0000) begin
                mismatched++;
                $display("FAIL idle_full[%0d]: busy=%b wen=%b ready=%b required all 0", n, s_busy, s_wen, s_ready);
            end
        end
        fifo_full = 1'b0;
        cycle();
        compared++;
        if (s_busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_arb_cycle: busy got %b required 0", s_busy);
        end
        cycle();
        compared++;
        if (s_busy !== 1'b1 || s_gid !== 2'd3 || s_wen !== 1'b1 || s_data !== 8'h30) begin
            mismatched++;
            $display("FAIL idle_first_grant: busy=%b gid=%0d wen=%b data=%02h required 1/3/1/30",
                     s_busy, s_gid, s_wen, s_data);
        end
        run_until(8, 30, "idle_full");
        repeat (3) cycle();
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            compared++;
            if (got[k] !== exp_data[k]) begin
                mismatched++;
                $display("FAIL idle_data[%0d]: got %02h required %02h", k, got[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        reset_sources();
        clear_log();
        src_left[1] = -1;
        drive();
        run_until(1, 20, "midrst_pre");
        if (got.size() > 0) begin
            compared++;
            if (got[0] !== 8'h10) begin
                mismatched++;
                $display("FAIL midrst_first: got %02h required 10", got[0]);
            end
        end
        rst = 1'b1;
        #1;
        compared++;
        if (fifo_w_en !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin
            mismatched++;
            $display("FAIL midrst_outputs: wen=%b ready=%b busy=%b gid=%0d required 0/0000/0/0",
                     fifo_w_en, req_ready, busy, grant_id);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            src_left[i] = -1;
            src_cnt[i]  = 0;
        end
        drive();
        run_until(1, 20, "midrst_post");
        if (got.size() > 0) begin
            compared++;
            if (got_gid[0] != 0 || got[0] !== 8'h00) begin
                mismatched++;
                $display("FAIL midrst_regrant: gid %0d data %02h required gid 0 data 00", got_gid[0], got[0]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        fifo_full = 1'b0;
        reset_sources();
        test_reset();
        test_round_robin();
        test_single_requester();
        test_full_stall();
        test_valid_drop();
        test_full_in_idle();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, word width, equal to the downstream synchronous FIFO data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..16).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester write-request valid.
REQ-007 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester accept; a beat transfers when req_valid[i] & req_ready[i].
REQ-009 SHALL have port fifo_full  input  1  full flag from the downstream FIFO.
REQ-010 SHALL have port fifo_w_en  output  1  write enable to the downstream FIFO.
REQ-011 SHALL have port fifo_data_in  output  DATA_WIDTH  write data to the downstream FIFO.
REQ-012 SHALL have port grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
REQ-013 SHALL have port busy  output  1  high while in GRANT state.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-015 In IDLE with any req_valid high and fifo_full low, SHALL select the first valid requester, searching round-robin from last_grant+1 modulo NUM_REQ. It SHALL register that index into grant_id and move to GRANT on the next edge.
REQ-016 In IDLE, SHALL not grant while fifo_full is high; requests stay pending.
REQ-017 In GRANT, req_ready[grant_id] SHALL be high iff fifo_full is low; all other req_ready bits SHALL be low.
REQ-018 fifo_w_en SHALL be combinational: (state==GRANT) & req_valid[grant_id] & ~fifo_full. fifo_data_in SHALL be req_data slice grant_id.
REQ-019 A beat counter SHALL count accepted beats in GRANT. It SHALL hold while fifo_full is high or req_valid[grant_id] is low.
REQ-020 GRANT SHALL exit to IDLE on the edge where the MAX_BURST-th beat is accepted.
REQ-021 GRANT SHALL also exit to IDLE on any edge where req_valid[grant_id] is low and no beat is accepted.
REQ-022 On exit from GRANT, last_grant SHALL take grant_id and the beat counter SHALL clear to 0.
REQ-023 Each grant SHALL be followed by one IDLE (arbitration) cycle. A requester's first beat SHALL be accepted no earlier than one cycle after its valid is sampled in IDLE.
REQ-024 In IDLE, all req_ready bits and fifo_w_en SHALL be low. fifo_w_en SHALL never assert when fifo_full is high, so no write is dropped.
REQ-025 Beat counter width SHALL be $clog2(MAX_BURST+1) bits, with no wrap-around.

Reset
REQ-026 While rst is high, SHALL hold state=IDLE, grant_id=0, beat counter=0, last_grant=NUM_REQ-1 (requester 0 has first priority). Consequently req_ready=0, fifo_w_en=0, busy=0.
REQ-027 Reset asserted mid-burst SHALL abandon the burst immediately (asynchronously), with no further FIFO writes.

Structure
REQ-028 FSM state encodings (ST_IDLE, ST_GRANT) SHALL live in shared package sync_fifo_pkg, alongside the FIFO's width helpers.
REQ-029 The round-robin search SHALL be a combinational sub-module, rr_priority_picker (inputs: request vector, last index; outputs: found, index), instantiated once.

Verification (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8, FIFO DEPTH=16)
REQ-030 Reset mid-burst: rst pulsed during the 2nd beat of requester 1 -> fifo_w_en=0 the same cycle. After release, with all valid, grant_id=0 first.
REQ-031 All four requesters valid continuously, requester i sending 0xi0, 0xi1, ... -> FIFO receives 00..03, 10..13, 20..23, 30..33, then 00-series again, with one idle cycle between bursts.
REQ-032 Only requester 2 valid for 10 beats -> bursts of 4, 4, 2 beats, each grant_id=2, separated by one idle cycle.
REQ-033 fifo_full high for 3 cycles after beat 2 of a burst -> req_ready and fifo_w_en low for those 3 cycles, beat counter held at 2. Beats 3 and 4 follow once full clears.
REQ-034 Requester 0 drops valid after 2 beats while requester 1 is valid -> GRANT exits, one idle cycle, then grant_id=1.
REQ-035 fifo_full high in IDLE with requests 0 and 3 pending -> busy stays 0. One cycle after full clears, grant goes to the round-robin winner.
